// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 4-bit ALU: valid/ready capture of {y, sel, k/n/c/v},
// in-order delivery to a stalling consumer, and sticky status flags.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_y,
  input  logic [1:0]       in_sel,
  input  logic             in_k,
  input  logic             in_n,
  input  logic             in_c,
  input  logic             in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_y,
  output logic [1:0]       out_sel,
  output logic [3:0]       out_flags,
  output logic [PTR_W:0]   count,
  input  logic             clr_sticky,
  output logic [3:0]       sticky_flags
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] sel;
    logic [3:0] flags;
  } entry_t;

  if ((DEPTH < 2) || (DEPTH > 16) || (DEPTH != (1 << PTR_W))) begin : g_param_check
    $error("alu_result_fifo: DEPTH must be a power of two in 2..16 with PTR_W = log2(DEPTH)");
  end

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               push;
  logic               pop;

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  // Logical ops (AND/OR) cannot produce carry or overflow, so those flags are dropped.
  always_comb begin
    wr_entry.y     = in_y;
    wr_entry.sel   = in_sel;
    wr_entry.flags = {in_k, in_n, (in_sel[1] ? 2'b00 : {in_c, in_v})};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Clear takes effect before a coincident push accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (clr_sticky) begin
      sticky_flags <= push ? wr_entry.flags : 4'b0000;
    end else if (push) begin
      sticky_flags <= sticky_flags | wr_entry.flags;
    end
  end

  // Head is gated by occupancy so the outputs read zero while empty and in reset.
  always_comb begin
    head      = mem[rd_ptr];
    out_y     = out_valid ? head.y     : 4'h0;
    out_sel   = out_valid ? head.sel   : 2'b00;
    out_flags = out_valid ? head.flags : 4'b0000;
  end

endmodule
